// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the score/timer controller
package score_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  typedef logic [3:0] bcd_t;
  localparam int SCORE_DIGITS = 3;
  localparam int TIME_DIGITS = 2;
  localparam logic [11:0] SCORE_MAX = 12'h999;
  function automatic logic [7:0] to_bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit with increment/decrement and carry/borrow out
module bcd_digit
  import score_pkg::*;
(
  input  bcd_t d,
  input  logic inc,
  input  logic dec,
  output bcd_t q,
  output logic co,
  output logic bo
);
  assign co = inc & (d == 4'd9);
  assign bo = dec & (d == 4'd0);
  assign q  = co ? 4'd0 : bo ? 4'd9 : inc ? d + 4'd1 : dec ? d - 4'd1 : d;
endmodule

// File: rtl/score_timer_ctrl.sv
// score_timer_ctrl: round FSM, BCD score keeper and countdown driven by slow_clk ticks
module score_timer_ctrl
  import score_pkg::*;
#(
  parameter int TICKS_PER_SEC = 5,
  parameter int GAME_SECONDS  = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slow_clk,
  input  logic        start,
  input  logic        hit,
  input  logic        miss,
  output logic [11:0] score_bcd,
  output logic [7:0]  time_bcd,
  output logic        game_active,
  output logic        game_over
);
  localparam int SW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(TICKS_PER_SEC - 1);
  localparam logic [7:0] TIME_INIT = to_bcd8(GAME_SECONDS);
  logic rst_meta_q, rst_n_q;
  logic sync1_q, sync2_q, hist_q, tick;
  state_t state_q, state_d;
  logic [11:0] score_q, score_d, score_nxt;
  logic [7:0] time_q, time_d, time_nxt;
  logic [SW-1:0] sub_q, sub_d;
  logic [SCORE_DIGITS:0] sc_c, sc_b;
  logic [TIME_DIGITS:0] t_b;
  logic [TIME_DIGITS-1:0] unused_t_co;
  logic play, sec;
  // reset asserts immediately and releases two clk edges later
  always_ff @(posedge clk or negedge reset)
    if (!reset) {rst_meta_q, rst_n_q} <= 2'b00;
    else {rst_meta_q, rst_n_q} <= {1'b1, rst_meta_q};
  // slow_clk synchronizer plus history flop for rising-edge detect
  always_ff @(posedge clk or negedge rst_n_q)
    if (!rst_n_q) {sync1_q, sync2_q, hist_q} <= 3'b000;
    else {sync1_q, sync2_q, hist_q} <= {slow_clk, sync1_q, sync2_q};
  assign tick = sync2_q & ~hist_q;
  assign play = state_q == PLAY;
  assign sec = play & tick & (sub_q == SUB_LAST);
  assign sc_c[0] = play & hit & ~miss;
  assign sc_b[0] = play & miss & ~hit;
  assign t_b[0] = sec;
  genvar i;
  for (i = 0; i < SCORE_DIGITS; i++) begin : g_score
    bcd_digit u_dig (
      .d(score_q[4*i +: 4]), .inc(sc_c[i]), .dec(sc_b[i]),
      .q(score_nxt[4*i +: 4]), .co(sc_c[i+1]), .bo(sc_b[i+1])
    );
  end
  for (i = 0; i < TIME_DIGITS; i++) begin : g_time
    bcd_digit u_dig (
      .d(time_q[4*i +: 4]), .inc(1'b0), .dec(t_b[i]),
      .q(time_nxt[4*i +: 4]), .co(unused_t_co[i]), .bo(t_b[i+1])
    );
  end
  // next state: load a fresh round on start, otherwise score and count down in PLAY;
  // a carry/borrow out of the top digit means saturation/floor, so the value is held
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    time_d = time_q;
    sub_d = sub_q;
    if (!play && start) begin
      state_d = PLAY;
      score_d = '0;
      time_d = TIME_INIT;
      sub_d = '0;
    end else if (play) begin
      score_d = (sc_c[SCORE_DIGITS] | sc_b[SCORE_DIGITS]) ? score_q : score_nxt;
      time_d = t_b[TIME_DIGITS] ? time_q : time_nxt;
      sub_d = !tick ? sub_q : sec ? '0 : sub_q + SW'(1);
      state_d = (sec && time_q == 8'h01) ? OVER : PLAY;
    end
  end
  // game state registers
  always_ff @(posedge clk or negedge rst_n_q)
    if (!rst_n_q) begin
      state_q <= IDLE;
      score_q <= '0;
      time_q <= TIME_INIT;
      sub_q <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      time_q <= time_d;
      sub_q <= sub_d;
    end
  assign score_bcd = score_q;
  assign time_bcd = time_q;
  assign game_active = state_q == PLAY;
  assign game_over = state_q == OVER;
endmodule

// File: tb/tb_score_timer_ctrl.sv
// tb_score_timer_ctrl: directed self-checking bench for score_timer_ctrl
module tb_score_timer_ctrl;
  logic clk = 0, reset = 0, slow_clk = 0, start = 0, hit = 0, miss = 0;
  logic [11:0] sa, sb;
  logic [7:0] ta, tb_t;
  logic aa, ao, ba, bo;
  int n_cmp = 0, n_err = 0, tick_cnt = 0;
  always #5 clk = ~clk;
  score_timer_ctrl dut_a (
    .clk(clk), .reset(reset), .slow_clk(slow_clk), .start(start), .hit(hit), .miss(miss),
    .score_bcd(sa), .time_bcd(ta), .game_active(aa), .game_over(ao)
  );
  score_timer_ctrl #(.TICKS_PER_SEC(2), .GAME_SECONDS(3)) dut_b (
    .clk(clk), .reset(reset), .slow_clk(slow_clk), .start(start), .hit(hit), .miss(miss),
    .score_bcd(sb), .time_bcd(tb_t), .game_active(ba), .game_over(bo)
  );
  always @(negedge clk) if (dut_b.tick) tick_cnt++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pulse(input logic h, input logic m, input logic s, input int n);
    @(negedge clk);
    hit = h; miss = m; start = s;
    repeat (n) @(negedge clk);
    hit = 0; miss = 0; start = 0;
  endtask
  task automatic slow_edge();
    @(negedge clk);
    slow_clk = 1;
    repeat (6) @(negedge clk);
    slow_clk = 0;
    repeat (6) @(negedge clk);
  endtask
  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] exp_t [1:5];
    logic found;
    int base;
    exp_t = '{8'h03, 8'h02, 8'h02, 8'h01, 8'h01};
    repeat (8) begin
      @(negedge clk);
      hit = 1'($urandom); miss = 1'($urandom); start = 1'($urandom); slow_clk = 1'($urandom);
    end
    check("rst_score", sa, 12'h000);
    check("rst_time_a", ta, 8'h30);
    check("rst_time_b", tb_t, 8'h03);
    check("rst_flags", {aa, ao, ba, bo}, 4'b0000);
    hit = 0; miss = 0; start = 0; slow_clk = 0;
    @(negedge clk) reset = 1;
    repeat (4) @(negedge clk);
    pulse(1, 0, 0, 5);
    check("idle_hits", sb, 12'h000);
    check("idle_flags", {ba, bo}, 2'b00);
    pulse(0, 0, 1, 1);
    check("start_active", {aa, ba}, 2'b11);
    check("start_time", ta, 8'h30);
    pulse(1, 0, 0, 12);
    pulse(0, 1, 0, 3);
    check("score_9", sb, 12'h009);
    pulse(1, 1, 0, 1);
    check("hit_miss", sb, 12'h009);
    pulse(0, 0, 1, 1);
    check("start_in_play", {ba, sb}, {1'b1, 12'h009});
    pulse(0, 1, 0, 9);
    check("to_zero", sb, 12'h000);
    pulse(0, 1, 0, 1);
    check("floor", sb, 12'h000);
    pulse(1, 0, 0, 99);
    check("score_99", sb, 12'h099);
    pulse(1, 0, 0, 1);
    check("carry_100", sb, 12'h100);
    pulse(1, 0, 0, 898);
    check("score_998", sb, 12'h998);
    pulse(1, 0, 0, 3);
    check("saturate", sb, 12'h999);
    @(negedge clk);
    reset = 0;
    #1;
    check("async_rst", {ba, bo, sb, tb_t}, {2'b00, 12'h000, 8'h03});
    @(negedge clk) reset = 1;
    repeat (3) @(negedge clk);
    check("rst_idle", {ba, bo}, 2'b00);
    pulse(0, 0, 1, 1);
    pulse(1, 0, 0, 7);
    check("score_7", {sb, tb_t}, {12'h007, 8'h03});
    for (int k = 1; k <= 5; k++) begin
      slow_edge();
      check($sformatf("time_after_%0d", k), tb_t, exp_t[k]);
    end
    @(negedge clk) slow_clk = 1;
    found = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bo) begin
        found = 1;
        break;
      end
    end
    check("over_latency", found, 1);
    @(negedge clk);
    check("over_state", {bo, ba, tb_t, sb}, {2'b10, 8'h00, 12'h007});
    slow_clk = 0;
    repeat (6) @(negedge clk);
    slow_edge();
    slow_edge();
    pulse(1, 0, 0, 3);
    pulse(0, 1, 0, 2);
    check("over_frozen", {bo, tb_t, sb}, {1'b1, 8'h00, 12'h007});
    pulse(0, 0, 1, 1);
    check("restart", {ba, bo, sb, tb_t}, {2'b10, 12'h000, 8'h03});
    base = tick_cnt;
    for (int i = 0; i < 10; i++) begin
      #($urandom_range(25, 60)) slow_clk = 1;
      #($urandom_range(25, 60)) slow_clk = 0;
    end
    repeat (5) @(negedge clk);
    check("jitter_ticks", tick_cnt - base, 10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
